// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the six-digit multiplexed 7-segment clock display scanner.
package seg_scan_pkg;

    localparam int unsigned SCAN_DIV_DEF     = 50000;
    localparam int unsigned BLINK_FRAMES_DEF = 64;
    localparam int unsigned NUM_DIGITS       = 6;
    localparam int unsigned NIB_W            = 4;
    localparam int unsigned SEG_W            = 7;
    localparam int unsigned IDX_W            = 3;

    // Digit slot order, least significant digit first; an[i] enables slot i.
    localparam logic [IDX_W-1:0] IDX_SEC_ONES  = 3'd0;
    localparam logic [IDX_W-1:0] IDX_SEC_TENS  = 3'd1;
    localparam logic [IDX_W-1:0] IDX_MIN_ONES  = 3'd2;
    localparam logic [IDX_W-1:0] IDX_MIN_TENS  = 3'd3;
    localparam logic [IDX_W-1:0] IDX_HOUR_ONES = 3'd4;
    localparam logic [IDX_W-1:0] IDX_HOUR_TENS = 3'd5;

    // Active-low segment codes, bit0 = a ... bit6 = g.
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 6'h3F;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } time_bcd_t;

    // Select the BCD nibble shown in a given digit slot.
    function automatic logic [NIB_W-1:0] digit_nibble(input time_bcd_t t,
                                                      input logic [IDX_W-1:0] idx);
        logic [NIB_W-1:0] nib;
        nib = '0;
        case (idx)
            IDX_SEC_ONES:  nib = t.sec[3:0];
            IDX_SEC_TENS:  nib = t.sec[7:4];
            IDX_MIN_ONES:  nib = t.min[3:0];
            IDX_MIN_TENS:  nib = t.min[7:4];
            IDX_HOUR_ONES: nib = t.hour[3:0];
            IDX_HOUR_TENS: nib = t.hour[7:4];
            default:       nib = '0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder; non-decimal nibbles go blank.
module bcd_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [NIB_W-1:0] i_bcd,
    output logic [SEG_W-1:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
            default: o_seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Six-digit HH:MM:SS multiplexed display scanner with per-pair blinking.
// Optional macro SEG_LZ_BLANK_EN blanks the hour-tens digit when it is zero.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = SCAN_DIV_DEF,
    parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            bcd_sec,
    input  logic [7:0]            bcd_min,
    input  logic [7:0]            bcd_hour,
    input  logic [2:0]            blink_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp
);

    localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(BLINK_FRAMES - 1);

    logic [PRESC_W-1:0]    r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [FRAME_W-1:0]    r_frame;
    logic                  r_phase;
    time_bcd_t             r_snap;
    logic [NUM_DIGITS-1:0] r_an;
    logic [SEG_W-1:0]      r_seg;
    logic                  r_dp;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_frame_wrap;
    logic [NIB_W-1:0]      w_nib;
    logic [SEG_W-1:0]      w_dec;
    logic                  w_pair_blink;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [SEG_W-1:0]      w_seg_nxt;
    logic                  w_dp_nxt;

    assign w_tick       = (r_presc == PRESC_MAX);
    assign w_wrap       = w_tick && (r_idx == IDX_HOUR_TENS);
    assign w_frame_wrap = w_wrap && (r_frame == FRAME_MAX);
    assign w_nib        = digit_nibble(r_snap, r_idx);

    bcd_to_seg7 u_dec (
        .i_bcd   (w_nib),
        .o_seg_c (w_dec)
    );

    // Blink enable is taken live from the mask, one bit per digit pair.
    always_comb begin
        w_pair_blink = 1'b0;
        case (r_idx)
            IDX_SEC_ONES, IDX_SEC_TENS:   w_pair_blink = blink_mask[0];
            IDX_MIN_ONES, IDX_MIN_TENS:   w_pair_blink = blink_mask[1];
            IDX_HOUR_ONES, IDX_HOUR_TENS: w_pair_blink = blink_mask[2];
            default:                      w_pair_blink = 1'b0;
        endcase
    end

    // Next display word for the slot currently addressed by r_idx.
    always_comb begin
        w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
        w_seg_nxt = (r_phase && w_pair_blink) ? SEG_BLANK : w_dec;
        w_dp_nxt  = !((r_idx == IDX_MIN_ONES) || (r_idx == IDX_HOUR_ONES));
`ifdef SEG_LZ_BLANK_EN
        if ((r_idx == IDX_HOUR_TENS) && (r_snap.hour[7:4] == 4'd0)) begin
            w_an_nxt  = AN_ALL_OFF;
            w_seg_nxt = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            r_phase <= 1'b0;
            r_snap  <= '0;
            r_an    <= AN_ALL_OFF;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end
            // Frame boundary: capture the time so a whole frame shows one coherent value.
            if (w_wrap) begin
                r_snap  <= time_bcd_t'({bcd_hour, bcd_min, bcd_sec});
                r_frame <= w_frame_wrap ? '0 : r_frame + FRAME_W'(1);
            end
            if (w_frame_wrap) begin
                r_phase <= ~r_phase;
            end
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a frame-level reference predicts each cycle's display word.
module tb_seg_scan;

    localparam int SD        = 4;
    localparam int BF        = 2;
    localparam int FRAME_CYC = SD * 6;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset1;
    logic [7:0] bcd_sec;
    logic [7:0] bcd_min;
    logic [7:0] bcd_hour;
    logic [2:0] blink_mask;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an1;
    logic [6:0] seg1;
    logic       dp1;

    out_t        exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    logic [23:0] m_snap       = '0;

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) u_dut (
        .clk(clk), .reset(reset), .bcd_sec(bcd_sec), .bcd_min(bcd_min),
        .bcd_hour(bcd_hour), .blink_mask(blink_mask), .an(an), .seg(seg), .dp(dp)
    );

    seg_scan #(.SCAN_DIV(1), .BLINK_FRAMES(BF)) u_dut1 (
        .clk(clk), .reset(reset1), .bcd_sec(bcd_sec), .bcd_min(bcd_min),
        .bcd_hour(bcd_hour), .blink_mask(blink_mask), .an(an1), .seg(seg1), .dp(dp1)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;  4'd3: s = 7'h30;
            4'd4: s = 7'h19;  4'd5: s = 7'h12;  4'd6: s = 7'h02;  4'd7: s = 7'h78;
            4'd8: s = 7'h00;  4'd9: s = 7'h10;  default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Expected display after the n-th clock edge since reset release.
    function automatic out_t model(input int n, input logic [23:0] snap, input logic [2:0] mask);
        out_t       o;
        int         s;
        int         idx;
        int         fr;
        logic [3:0] nib;
        s   = (n - 1) / SD;
        idx = s % 6;
        fr  = s / 6;
        nib = snap[idx*4 +: 4];
        o.an      = 6'h3F;
        o.an[idx] = 1'b0;
        o.seg     = ref_seg(nib);
        o.dp      = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
        if (((fr / BF) % 2) == 1 && mask[idx/2]) o.seg = 7'h7F;
`ifdef SEG_LZ_BLANK_EN
        if (idx == 5 && nib == 4'd0) begin
            o.an  = 6'h3F;
            o.seg = 7'h7F;
        end
`endif
        return o;
    endfunction

    // Push the prediction for the coming edge, then clock it through.
    task automatic drive_cycle();
        exp_q.push_back(model(cyc + 1, m_snap, blink_mask));
        if (((cyc + 1) % FRAME_CYC) == 0) m_snap = {bcd_hour, bcd_min, bcd_sec};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start();
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1'b1;
        cyc    = 0;
        m_snap = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        out_t e;
        bcd_sec = 8'h00; bcd_min = 8'h00; bcd_hour = 8'h00; blink_mask = 3'b000;
        reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_values got an=%b seg=%h dp=%b want an=111111 seg=7f dp=1", an, seg, dp);
        end
        reset = 1'b1; cyc = 0; m_snap = '0; exp_q.delete();
        repeat (30) begin
            drive_cycle();
            e = exp_q.pop_front();
            tests_run++;
            if ({an, seg, dp} !== e) begin
                tests_failed++;
                $display("FAIL reset_release cyc=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (cyc == 1 || cyc == 4 || cyc == 5 || cyc == 25) begin
                tests_run++;
                if (an !== ((cyc == 5) ? 6'b111101 : 6'b111110)) begin
                    tests_failed++;
                    $display("FAIL release_timing cyc=%0d got an=%b", cyc, an);
                end
            end
        end
    endtask

    task automatic test_basic();
        out_t       e;
        logic [6:0] want [6];
        want = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        bcd_hour = 8'h12; bcd_min = 8'h34; bcd_sec = 8'h56; blink_mask = 3'b000;
        start();
        repeat (2 * FRAME_CYC) begin
            drive_cycle();
            e = exp_q.pop_front();
            tests_run++;
            if ({an, seg, dp} !== e) begin
                tests_failed++;
                $display("FAIL basic cyc=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (cyc > FRAME_CYC && ((cyc - FRAME_CYC - 1) % SD) == 0) begin
                tests_run++;
                if (seg !== want[(cyc - FRAME_CYC - 1) / SD]) begin
                    tests_failed++;
                    $display("FAIL basic_digit cyc=%0d got seg=%h want %h",
                             cyc, seg, want[(cyc - FRAME_CYC - 1) / SD]);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        out_t e;
        bcd_hour = 8'h12; bcd_min = 8'h34; bcd_sec = 8'h56; blink_mask = 3'b000;
        start();
        repeat (3 * FRAME_CYC) begin
            drive_cycle();
            e = exp_q.pop_front();
            tests_run++;
            if ({an, seg, dp} !== e) begin
                tests_failed++;
                $display("FAIL snapshot cyc=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (cyc == FRAME_CYC + 3 * SD + 1) bcd_sec = 8'h57;
            if (cyc == 2 * FRAME_CYC + 1 || cyc == 2 * FRAME_CYC - 3) begin
                tests_run++;
                if (seg !== ((cyc > 2 * FRAME_CYC) ? 7'h78 : 7'h79)) begin
                    tests_failed++;
                    $display("FAIL snapshot_hold cyc=%0d got seg=%h", cyc, seg);
                end
            end
        end
    endtask

    task automatic test_blink();
        out_t e;
        bcd_hour = 8'h12; bcd_min = 8'h34; bcd_sec = 8'h56; blink_mask = 3'b010;
        start();
        repeat (6 * FRAME_CYC) begin
            drive_cycle();
            e = exp_q.pop_front();
            tests_run++;
            if ({an, seg, dp} !== e) begin
                tests_failed++;
                $display("FAIL blink cyc=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (cyc == 2 * FRAME_CYC + 2 * SD + 1) begin
                tests_run++;
                if (seg !== 7'h7F || an !== 6'b111011 || dp !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL blink_off cyc=%0d got an=%b seg=%h dp=%b", cyc, an, seg, dp);
                end
            end
            if (cyc == 4 * FRAME_CYC + 2 * SD + 1) begin
                tests_run++;
                if (seg !== 7'h19) begin
                    tests_failed++;
                    $display("FAIL blink_on cyc=%0d got seg=%h want 19", cyc, seg);
                end
            end
        end
        blink_mask = 3'b000;
    endtask

    task automatic test_invalid_lz();
        out_t e;
        bcd_hour = 8'h08; bcd_min = 8'h3C; bcd_sec = 8'h00; blink_mask = 3'b000;
        start();
        repeat (2 * FRAME_CYC) begin
            drive_cycle();
            e = exp_q.pop_front();
            tests_run++;
            if ({an, seg, dp} !== e) begin
                tests_failed++;
                $display("FAIL invalid_lz cyc=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (cyc == FRAME_CYC + 2 * SD + 1) begin
                tests_run++;
                if (seg !== 7'h7F) begin
                    tests_failed++;
                    $display("FAIL invalid_nibble got seg=%h want 7f", seg);
                end
            end
            if (cyc == FRAME_CYC + 5 * SD + 1) begin
                tests_run++;
`ifdef SEG_LZ_BLANK_EN
                if (an !== 6'h3F || seg !== 7'h7F) begin
`else
                if (an !== 6'b011111 || seg !== 7'h40) begin
`endif
                    tests_failed++;
                    $display("FAIL hour_tens_zero got an=%b seg=%h", an, seg);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        out_t e;
        bcd_hour = 8'h12; bcd_min = 8'h34; bcd_sec = 8'h56; blink_mask = 3'b000;
        start();
        repeat (FRAME_CYC + SD + 2) begin
            drive_cycle();
            void'(exp_q.pop_front());
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1}) begin
            tests_failed++;
            $display("FAIL mid_reset got an=%b seg=%h dp=%b", an, seg, dp);
        end
        reset = 1'b1; cyc = 0; m_snap = '0; exp_q.delete();
        repeat (FRAME_CYC + 4) begin
            drive_cycle();
            e = exp_q.pop_front();
            tests_run++;
            if ({an, seg, dp} !== e) begin
                tests_failed++;
                $display("FAIL mid_reset_restart cyc=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_fast_reset();
        logic [5:0] want_an [4];
        want_an = '{6'b111110, 6'b111101, 6'b111011, 6'b110111};
        reset1 = 1'b0;
        @(posedge clk); #1;
        reset1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (an1 !== want_an[i]) begin
                tests_failed++;
                $display("FAIL fast_scan step=%0d got an=%b want %b", i, an1, want_an[i]);
            end
        end
        reset1 = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({an1, seg1, dp1} !== {6'h3F, 7'h7F, 1'b1}) begin
            tests_failed++;
            $display("FAIL fast_reset got an=%b seg=%h dp=%b", an1, seg1, dp1);
        end
        reset1 = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({an1, seg1, dp1} !== {6'b111110, 7'h40, 1'b1}) begin
            tests_failed++;
            $display("FAIL fast_release got an=%b seg=%h dp=%b", an1, seg1, dp1);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({an1, seg1} !== {6'b111101, 7'h40}) begin
            tests_failed++;
            $display("FAIL fast_next got an=%b seg=%h", an1, seg1);
        end
    endtask

    initial begin
        reset = 1'b0; reset1 = 1'b0;
        bcd_sec = '0; bcd_min = '0; bcd_hour = '0; blink_mask = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_snapshot();
        test_blink();
        test_invalid_lz();
        test_mid_reset();
        test_fast_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
